id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 XLEN, default 32, datapath width of operand, immediate and PC fields.
REQ-002 SCNT_W, default 16, width of saturating stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 validD  in  1  decode slot holds a real instruction.
REQ-006 regwriteD, reg_destD, alusrcD, branchD, memwriteD, memtoregD  in  1 each  decoded control bits.
REQ-007 aluopD  in  2  decoded ALU op class (00 add, 01 sub/branch, 10 funct-decoded).
REQ-008 rd1D, rd2D  in  XLEN  register file read data.
REQ-009 immD, pcD  in  XLEN  immediate and PC of decode instruction.
REQ-010 rs1D, rs2D, rdD  in  5  register specifiers.
REQ-011 flushE  in  1  branch taken in execute; squash next EX contents.
REQ-012 validE, regwriteE, reg_destE, alusrcE, branchE, memwriteE, memtoregE  out  1 each  registered copies.
REQ-013 aluopE  out  2; rd1E, rd2E, immE, pcE  out  XLEN; rs1E, rs2E, rdE  out  5  registered copies.
REQ-014 stallF, stallD  out  1 each  combinational hold requests to PC and IF/ID registers.
REQ-015 stall_cnt  out  SCNT_W  number of load-use stall cycles since reset.

Function
REQ-016 Load-use hazard hz = validE & memtoregE & (rdE != 0) & validD & (rdE == rs1D | rdE == rs2D), combinational.
REQ-017 stallF = stallD = hz & ~flushE.
REQ-018 Normal edge (no flushE, no hz): every E field loads its D counterpart; validE <= validD.
REQ-019 Hazard edge (hz, no flushE): bubble inserted: validE and all seven control bits/aluopE cleared to 0, data and specifier fields cleared to 0; D-side instruction retried next cycle.
REQ-020 Flush edge (flushE=1): bubble inserted as REQ-019 regardless of hz; flush has priority.
REQ-021 validD=0 at a normal edge: control bits still captured but validE=0; hazard logic ignores slots with validE=0 or validD=0.
REQ-022 Writes to x0 never create a hazard (rdE=0 excluded).
REQ-023 Latency: one cycle D to E; no internal state beyond the E register set and stall_cnt.
REQ-024 stall_cnt increments by 1 on each edge where stallD=1; saturates at 2^SCNT_W-1, no wrap.
REQ-025 Back-to-back loads: a second dependent instruction after a bubble sees validE=0 and proceeds; at most one stall cycle per load-use pair.

Reset
REQ-026 reset_n=0 asynchronously clears all E outputs and stall_cnt to 0, hence validE=0 and stallF=stallD=0 immediately.
REQ-027 Reset asserted mid-stall aborts the stall; first edge after release performs a normal load of D fields.

Structure
REQ-028 Shared package pipe_pkg holds XLEN default, ALUOP encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT) and the REG_X0 constant.
REQ-029 Hazard equation lives in sub-module hazard_detect (pure combinational, inputs validE, memtoregE, rdE, validD, rs1D, rs2D, flushE; outputs hz, stall).
REQ-030 E register set implemented as one always block with async reset; no latches, no X on any output after reset.

Verification
REQ-031 Reset: reset_n=0 with random D inputs -> all E outputs 0, stall_cnt=0, stallF=stallD=0 without a clock edge.
REQ-032 Passthrough: addi x5,x0,7 (regwriteD=1, alusrcD=1, aluopD=00, immD=7, rdD=5) -> next cycle regwriteE=1, alusrcE=1, immE=7, rdE=5, validE=1.
REQ-033 Load-use: lw x6 in E (memtoregE=1, rdE=6), add x7,x6,x1 in D -> stallF=stallD=1 one cycle, next cycle validE=0, following cycle add in E, stall_cnt=1.
REQ-034 x0 exclusion: lw x0 in E, D reads rs1D=0 -> stallD=0, no bubble.
REQ-035 Flush priority: hz=1 and flushE=1 same cycle -> stallD=0, next cycle validE=0, all controls 0, stall_cnt unchanged.
REQ-036 Saturation: SCNT_W=2, force 5 consecutive hazard cycles -> stall_cnt sequence 1,2,3,3,3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width default, ALU op classes and x0.
package pipe_pkg;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-side inputs, execute-side register outputs and stall status of the ID/EX stage.
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int SCNT_W = 16
);
  logic            validD, regwriteD, reg_destD, alusrcD, branchD, memwriteD, memtoregD;
  logic [1:0]      aluopD;
  logic [XLEN-1:0] rd1D, rd2D, immD, pcD;
  logic [4:0]      rs1D, rs2D, rdD;
  logic            flushE;

  logic            validE, regwriteE, reg_destE, alusrcE, branchE, memwriteE, memtoregE;
  logic [1:0]      aluopE;
  logic [XLEN-1:0] rd1E, rd2E, immE, pcE;
  logic [4:0]      rs1E, rs2E, rdE;
  logic            stallF, stallD;
  logic [SCNT_W-1:0] stall_cnt;

  modport master (
    output validD, regwriteD, reg_destD, alusrcD, branchD, memwriteD, memtoregD,
           aluopD, rd1D, rd2D, immD, pcD, rs1D, rs2D, rdD, flushE,
    input  validE, regwriteE, reg_destE, alusrcE, branchE, memwriteE, memtoregE,
           aluopE, rd1E, rd2E, immE, pcE, rs1E, rs2E, rdE, stallF, stallD, stall_cnt
  );

  modport slave (
    input  validD, regwriteD, reg_destD, alusrcD, branchD, memwriteD, memtoregD,
           aluopD, rd1D, rd2D, immD, pcD, rs1D, rs2D, rdD, flushE,
    output validE, regwriteE, reg_destE, alusrcE, branchE, memwriteE, memtoregE,
           aluopE, rd1E, rd2E, immE, pcE, rs1E, rs2E, rdE, stallF, stallD, stall_cnt
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in decode.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic       validE,
  input  logic       memtoregE,
  input  logic [4:0] rdE,
  input  logic       validD,
  input  logic [4:0] rs1D,
  input  logic [4:0] rs2D,
  input  logic       flushE,
  output logic       hz,
  output logic       stall
);
  assign hz    = validE & memtoregE & (rdE != REG_X0) & validD & ((rdE == rs1D) | (rdE == rs2D));
  // A taken branch squashes the dependent instruction anyway, so no hold is needed.
  assign stall = hz & ~flushE;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and saturating stall counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int SCNT_W = 16
)
(
  input  logic         clk,
  input  logic         reset_n,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            reg_dest;
    logic            alusrc;
    logic            branch;
    logic            memwrite;
    logic            memtoreg;
    logic [1:0]      aluop;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ex_t;

  ex_t               ex_d, ex_q;
  logic [SCNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic              hz, stall;

  hazard_detect u_hazard (
    .validE    (ex_q.valid),
    .memtoregE (ex_q.memtoreg),
    .rdE       (ex_q.rd),
    .validD    (bus.validD),
    .rs1D      (bus.rs1D),
    .rs2D      (bus.rs2D),
    .flushE    (bus.flushE),
    .hz        (hz),
    .stall     (stall)
  );

  always_comb begin
    ex_d = '{valid: bus.validD, regwrite: bus.regwriteD, reg_dest: bus.reg_destD,
             alusrc: bus.alusrcD, branch: bus.branchD, memwrite: bus.memwriteD,
             memtoreg: bus.memtoregD, aluop: bus.aluopD, rd1: bus.rd1D, rd2: bus.rd2D,
             imm: bus.immD, pc: bus.pcD, rs1: bus.rs1D, rs2: bus.rs2D, rd: bus.rdD};
    // Bubble: flush and load-use both leave a fully zeroed slot in EX.
    if (bus.flushE || hz) ex_d = '0;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + SCNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.validE    = ex_q.valid;
  assign bus.regwriteE = ex_q.regwrite;
  assign bus.reg_destE = ex_q.reg_dest;
  assign bus.alusrcE   = ex_q.alusrc;
  assign bus.branchE   = ex_q.branch;
  assign bus.memwriteE = ex_q.memwrite;
  assign bus.memtoregE = ex_q.memtoreg;
  assign bus.aluopE    = ex_q.aluop;
  assign bus.rd1E      = ex_q.rd1;
  assign bus.rd2E      = ex_q.rd2;
  assign bus.immE      = ex_q.imm;
  assign bus.pcE       = ex_q.pc;
  assign bus.rs1E      = ex_q.rs1;
  assign bus.rs2E      = ex_q.rs2;
  assign bus.rdE       = ex_q.rd;
  assign bus.stallF    = stall;
  assign bus.stallD    = stall;
  assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction vectors, expected EX contents queued per edge.
module tb_id_ex_stage;
  import pipe_pkg::*;

  localparam int XLEN   = 32;
  localparam int SCNT_W = 2;

  typedef struct packed {
    logic            valid;
    logic            regwrite;
    logic            reg_dest;
    logic            alusrc;
    logic            branch;
    logic            memwrite;
    logic            memtoreg;
    logic [1:0]      aluop;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } ins_t;

  typedef struct {
    ins_t              e;
    logic [SCNT_W-1:0] cnt;
    int                tag;
  } exp_t;

  logic clk;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;
  int   step_no = 0;
  exp_t exp_q[$];

  id_ex_stage_if #(.XLEN(XLEN), .SCNT_W(SCNT_W)) bus ();
  id_ex_stage #(.XLEN(XLEN), .SCNT_W(SCNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic ins_t mk(input logic v, rw, rdst, asrc, br, mw, m2r, input logic [1:0] op,
                              input logic [31:0] r1, r2, imm, pc, input logic [4:0] s1, s2, d);
    ins_t t;
    t = '{valid: v, regwrite: rw, reg_dest: rdst, alusrc: asrc, branch: br, memwrite: mw,
          memtoreg: m2r, aluop: op, rd1: r1, rd2: r2, imm: imm, pc: pc, rs1: s1, rs2: s2, rd: d};
    return t;
  endfunction

  function automatic ins_t get_e();
    ins_t t;
    t = '{valid: bus.validE, regwrite: bus.regwriteE, reg_dest: bus.reg_destE,
          alusrc: bus.alusrcE, branch: bus.branchE, memwrite: bus.memwriteE,
          memtoreg: bus.memtoregE, aluop: bus.aluopE, rd1: bus.rd1E, rd2: bus.rd2E,
          imm: bus.immE, pc: bus.pcE, rs1: bus.rs1E, rs2: bus.rs2E, rd: bus.rdE};
    return t;
  endfunction

  task automatic drive(input ins_t d, input logic flush);
    bus.validD    = d.valid;    bus.regwriteD = d.regwrite; bus.reg_destD = d.reg_dest;
    bus.alusrcD   = d.alusrc;   bus.branchD   = d.branch;   bus.memwriteD = d.memwrite;
    bus.memtoregD = d.memtoreg; bus.aluopD    = d.aluop;
    bus.rd1D = d.rd1; bus.rd2D = d.rd2; bus.immD = d.imm; bus.pcD = d.pc;
    bus.rs1D = d.rs1; bus.rs2D = d.rs2; bus.rdD = d.rd;
    bus.flushE = flush;
  endtask

  // Called just after a falling edge; queues what EX must hold after the next rising edge.
  task automatic step(input ins_t d, input logic flush, input logic exp_stall,
                      input logic bubble, input logic [SCNT_W-1:0] exp_cnt);
    exp_t x;
    step_no++;
    drive(d, flush);
    #1;
    check($sformatf("stallF step%0d", step_no), 160'(bus.stallF), 160'(exp_stall));
    check($sformatf("stallD step%0d", step_no), 160'(bus.stallD), 160'(exp_stall));
    x.e   = bubble ? ins_t'('0) : d;
    x.cnt = exp_cnt;
    x.tag = step_no;
    exp_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: one popped expectation per rising edge that has one queued.
  always begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check($sformatf("ex_regs step%0d", x.tag), 160'(get_e()), 160'(x.e));
      check($sformatf("stall_cnt step%0d", x.tag), 160'(bus.stall_cnt), 160'(x.cnt));
    end
  end

  initial begin
    ins_t nop_i, addi_i, lw6, add76, lw0, add8, lw9, dep9, lw10, inv10, use10, lw11, dep11, lw12, dep12;
    logic [SCNT_W-1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    nop_i  = '0;
    addi_i = mk(1,1,0,1,0,0,0,ALUOP_ADD,   32'h0,    32'h0,    32'd7,  32'h100, 5'd0,  5'd0, 5'd5);
    lw6    = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'h40,   32'h0,    32'd0,  32'h104, 5'd1,  5'd0, 5'd6);
    add76  = mk(1,1,1,0,0,0,0,ALUOP_FUNCT, 32'h1234, 32'h40,   32'd0,  32'h108, 5'd6,  5'd1, 5'd7);
    lw0    = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'h80,   32'h0,    32'd4,  32'h10c, 5'd3,  5'd0, 5'd0);
    add8   = mk(1,1,1,0,0,0,0,ALUOP_FUNCT, 32'h0,    32'h55,   32'd0,  32'h110, 5'd0,  5'd2, 5'd8);
    lw9    = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'h90,   32'h0,    32'd8,  32'h114, 5'd4,  5'd0, 5'd9);
    dep9   = mk(1,0,0,0,1,0,0,ALUOP_SUB,   32'h11,   32'h22,   32'h20, 32'h118, 5'd3,  5'd9, 5'd0);
    lw10   = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'ha0,   32'h0,    32'd12, 32'h200, 5'd5,  5'd0, 5'd10);
    inv10  = mk(0,1,0,1,0,0,1,ALUOP_ADD,   32'hdead, 32'hbeef, 32'd3,  32'h204, 5'd10, 5'd0, 5'd10);
    use10  = mk(1,1,1,0,0,1,0,ALUOP_FUNCT, 32'h7,    32'h8,    32'd0,  32'h208, 5'd10, 5'd2, 5'd13);
    lw11   = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'hb0,   32'h0,    32'd0,  32'h20c, 5'd6,  5'd0, 5'd11);
    dep11  = mk(1,1,1,0,0,0,0,ALUOP_FUNCT, 32'h3,    32'h4,    32'd0,  32'h210, 5'd11, 5'd7, 5'd14);
    lw12   = mk(1,1,0,1,0,0,1,ALUOP_ADD,   32'hc0,   32'h0,    32'd16, 32'h300, 5'd8,  5'd0, 5'd12);
    dep12  = mk(1,1,1,0,0,0,0,ALUOP_FUNCT, 32'h9,    32'ha,    32'd0,  32'h304, 5'd2,  5'd12, 5'd15);

    // Reset with random decode inputs: everything must be zero with no edge seen yet.
    reset_n = 1'b0;
    drive(ins_t'({$urandom, $urandom, $urandom, $urandom, $urandom}), 1'b0);
    #2;
    check("reset ex_regs", 160'(get_e()), 160'(nop_i));
    check("reset stall_cnt", 160'(bus.stall_cnt), 160'(0));
    check("reset stallF", 160'(bus.stallF), 160'(0));
    check("reset stallD", 160'(bus.stallD), 160'(0));

    @(negedge clk);
    reset_n = 1'b1;

    step(addi_i, 1'b0, 1'b0, 1'b0, 2'd0);
    step(lw6,    1'b0, 1'b0, 1'b0, 2'd0);
    step(add76,  1'b0, 1'b1, 1'b1, 2'd1);   // load-use: bubble
    step(add76,  1'b0, 1'b0, 1'b0, 2'd1);   // retry proceeds after bubble
    step(lw0,    1'b0, 1'b0, 1'b0, 2'd1);
    step(add8,   1'b0, 1'b0, 1'b0, 2'd1);   // rs1=x0 against lw x0: no hazard
    step(lw9,    1'b0, 1'b0, 1'b0, 2'd1);
    step(dep9,   1'b1, 1'b0, 1'b1, 2'd1);   // flush wins over hazard
    step(lw10,   1'b0, 1'b0, 1'b0, 2'd1);
    step(inv10,  1'b0, 1'b0, 1'b0, 2'd1);   // invalid D slot captured with validE=0
    step(use10,  1'b0, 1'b0, 1'b0, 2'd1);   // invalid E slot never stalls
    step(lw11,   1'b0, 1'b0, 1'b0, 2'd1);

    // Reset asserted while a stall is pending, released before the next edge.
    begin
      exp_t x;
      step_no++;
      drive(dep11, 1'b0);
      #1;
      check("midstall stallD before reset", 160'(bus.stallD), 160'(1));
      #1 reset_n = 1'b0;
      #1;
      check("midstall stallD in reset", 160'(bus.stallD), 160'(0));
      check("midstall stallF in reset", 160'(bus.stallF), 160'(0));
      check("midstall ex_regs in reset", 160'(get_e()), 160'(nop_i));
      check("midstall stall_cnt in reset", 160'(bus.stall_cnt), 160'(0));
      #1 reset_n = 1'b1;
      x.e = dep11; x.cnt = 2'd0; x.tag = step_no;
      exp_q.push_back(x);
      @(posedge clk);
      @(negedge clk);
    end

    for (int k = 0; k < 5; k++) begin
      step(lw12,  1'b0, 1'b0, 1'b0, (k == 0) ? 2'd0 : sat_exp[k-1]);
      step(dep12, 1'b0, 1'b1, 1'b1, sat_exp[k]);
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) check("scoreboard drained", 160'(exp_q.size()), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
